// File: rtl/uart_rx_fsm.sv
// Receive-side sequencer for the UART RX path: start detection, edge/bit counting, checker strobes.
// Optional `UART_RX_FRAME_ERR_EN adds a frame_err pulse for frames dropped on parity/stop errors.
module uart_rx_fsm #(
  parameter int DATA_width     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          RX_IN,
  input  logic [Prescale_width-1:0]     Prescale,
  input  logic                          PAR_EN,
  input  logic                          strt_glitch,
  input  logic                          par_err,
  input  logic                          stp_err,
  output logic [Prescale_width-1:0]     edge_cnt,
  output logic [$clog2(DATA_width)-1:0] bit_cnt,
  output logic                          dat_samp_en,
  output logic                          strt_chk_en,
  output logic                          par_chk_en,
  output logic                          stp_chk_en,
  output logic                          deser_en,
  output logic [2:0]                    fsm_state,
  output logic                          data_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                          frame_err
`endif
);

  localparam int BIT_W = $clog2(DATA_width);
  localparam logic [Prescale_width-1:0] P_ONE    = 1;
  localparam logic [BIT_W-1:0]          B_ONE    = 1;
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [Prescale_width-1:0] edge_cnt_q, edge_cnt_d;
  logic [Prescale_width-1:0] prescale_q, prescale_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      par_en_q, par_en_d;
  logic                      par_flag_q, par_flag_d;
  logic                      dat_samp_en_q, dat_samp_en_d;
  logic                      strt_chk_en_q, strt_chk_en_d;
  logic                      par_chk_en_q, par_chk_en_d;
  logic                      stp_chk_en_q, stp_chk_en_d;
  logic                      deser_en_q, deser_en_d;
  logic                      data_valid_q, data_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      bit_end;

  assign bit_end = (state_q != IDLE) && (edge_cnt_q == prescale_q - P_ONE);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_flag_d   = par_flag_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == IDLE) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + P_ONE;
    end

    case (state_q)
      IDLE: begin
        // Frame parameters are captured once here and frozen until the frame ends.
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
        end
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + B_ONE;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_flag_d = par_err;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d      = IDLE;
          data_valid_d = !stp_err && !par_flag_q;
          frame_err_d  = stp_err || par_flag_q;
          par_flag_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state register.
    dat_samp_en_d = (state_d != IDLE);
    strt_chk_en_d = (state_d == START);
    par_chk_en_d  = (state_d == PARITY);
    stp_chk_en_d  = (state_d == STOP);
    deser_en_d    = (state_d == DATA) && (edge_cnt_d == prescale_d - P_ONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      prescale_q    <= '0;
      par_en_q      <= 1'b0;
      par_flag_q    <= 1'b0;
      dat_samp_en_q <= 1'b0;
      strt_chk_en_q <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      deser_en_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      prescale_q    <= prescale_d;
      par_en_q      <= par_en_d;
      par_flag_q    <= par_flag_d;
      dat_samp_en_q <= dat_samp_en_d;
      strt_chk_en_q <= strt_chk_en_d;
      par_chk_en_q  <= par_chk_en_d;
      stp_chk_en_q  <= stp_chk_en_d;
      deser_en_q    <= deser_en_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign bit_cnt     = bit_cnt_q;
  assign dat_samp_en = dat_samp_en_q;
  assign strt_chk_en = strt_chk_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stp_chk_en  = stp_chk_en_q;
  assign deser_en    = deser_en_q;
  assign data_valid  = data_valid_q;
  assign fsm_state   = state_q;

`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame timing, strobes, error drops, glitch, back-to-back, reset.
// Checker inputs are randomised outside their bit-end cycle since the sequencer must ignore them.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk;
  logic          reset_n;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [PW-1:0] edge_cnt;
  logic [2:0]    bit_cnt;
  logic          dat_samp_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          deser_en;
  logic [2:0]    fsm_state;
  logic          data_valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic          frame_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  uart_rx_fsm #(.DATA_width(DW), .Prescale_width(PW)) dut (
    .clk(clk), .reset_n(reset_n), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .fsm_state(fsm_state), .data_valid(data_valid)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
            stp_chk_en, deser_en, data_valid, fsm_state};
  endfunction

  // Drives one frame and scores it. started=1 means RX_IN was already low in the prior cycle.
  task automatic run_frame(input int p, input bit pe, input bit perr, input bit serr,
                           input bit glitch, input bit started, input bit chain_next,
                           input logic [PW-1:0] new_p, input bit new_pe);
    int f, ncyc, par_cnt, par_first, dv_cnt, dv_cyc, fe_cnt, strt_cnt, samp_cnt;
    int edge_bad, bit_bad, extra;
    bit good;
    f = p * (2 + DW + int'(pe));
    ncyc = glitch ? p + 3 : f + 1;
    par_cnt = 0; par_first = -1; dv_cnt = 0; dv_cyc = -1; fe_cnt = 0;
    strt_cnt = 0; samp_cnt = 0; edge_bad = 0; bit_bad = 0; extra = 0;
    exp_q.delete();
    if (!glitch)
      for (int k = 0; k < DW; k++) exp_q.push_back(16'(p * (k + 2) - 1));
    if (!started) begin
      @(negedge clk);
      Prescale = PW'(p);
      PAR_EN = pe;
      RX_IN = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (deser_en) begin
        if (exp_q.size() == 0) extra++;
        else check("deser_cycle", 32'(c), 32'(exp_q.pop_front()));
      end
      if (par_chk_en) begin
        par_cnt++;
        if (par_first < 0) par_first = c;
      end
      if (data_valid) begin dv_cnt++; dv_cyc = c; end
`ifdef UART_RX_FRAME_ERR_EN
      if (frame_err) fe_cnt++;
`endif
      if (strt_chk_en) strt_cnt++;
      if (dat_samp_en) samp_cnt++;
      if (c < (glitch ? p : f) && int'(edge_cnt) != c % p) edge_bad++;
      if (!glitch && c >= p && c < (DW + 1) * p && int'(bit_cnt) != c / p - 1) bit_bad++;
      if (c == 0) check("first_cycle_state", 32'(fsm_state), 32'd1);
      if (c == 0) check("first_cycle_edge", 32'(edge_cnt), 32'd0);
      if (glitch && c == p) begin
        check("glitch_state", 32'(fsm_state), 32'd0);
        check("glitch_edge", 32'(edge_cnt), 32'd0);
      end
      if (!glitch && c == f) check("end_state", 32'(fsm_state), 32'd0);
      RX_IN = (chain_next && c == f) ? 1'b0 : 1'b1;
      strt_glitch = (c == p - 1) ? glitch : 1'($urandom_range(0, 1));
      par_err = (pe && c == (DW + 2) * p - 1) ? perr : 1'($urandom_range(0, 1));
      stp_err = (c == f - 1) ? serr : 1'($urandom_range(0, 1));
      if (c == 20) begin Prescale = new_p; PAR_EN = new_pe; end
    end
    good = !glitch && !serr && !(pe && perr);
    check("edge_cnt_track", 32'(edge_bad), 32'd0);
    check("bit_cnt_track", 32'(bit_bad), 32'd0);
    check("deser_missing", 32'(exp_q.size()), 32'd0);
    check("deser_extra", 32'(extra), 32'd0);
    check("par_chk_cycles", 32'(par_cnt), (pe && !glitch) ? 32'(p) : 32'd0);
    if (pe && !glitch) check("par_chk_first", 32'(par_first), 32'((DW + 1) * p));
    check("strt_chk_cycles", 32'(strt_cnt), 32'(p));
    check("samp_cycles", 32'(samp_cnt), glitch ? 32'(p) : 32'(f));
    check("dv_count", 32'(dv_cnt), {31'd0, good});
    if (good) check("dv_cycle", 32'(dv_cyc), 32'(f));
`ifdef UART_RX_FRAME_ERR_EN
    check("ferr_count", 32'(fe_cnt), {31'd0, !glitch && !good});
`else
    if (fe_cnt != 0) check("ferr_absent", 32'(fe_cnt), 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    PAR_EN = 1'b1;
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    #2;
    check("reset_outs", all_outs(), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", all_outs(), 32'd0);

    // Clean frame with parity: data_valid at 88.
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd13, 1'b0);
    // Parity error: dropped.
    run_frame(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0);
    // Stop error: dropped.
    run_frame(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 1'b0);
    // Start glitch at cycle 7.
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8, 1'b1);
    // No parity, Prescale=4: data_valid at 40.
    run_frame(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7, 1'b1);
    // Back-to-back: Prescale=16/no parity applied mid first frame, used by the second.
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0);
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd16, 1'b0);

    // Asynchronous reset at cycle 30 of a frame.
    repeat (2) @(negedge clk);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    Prescale = 6'd8; PAR_EN = 1'b1; RX_IN = 1'b0;
    @(negedge clk);
    RX_IN = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_reset_state", 32'(fsm_state), 32'd2);
    check("pre_reset_edge", 32'(edge_cnt), 32'd6);
    #1 reset_n = 1'b0;
    #1 check("async_reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    check("held_reset_outs", all_outs(), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", all_outs(), 32'd0);
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side sequencer for the UART_RX path. It detects a start condition on the serial line, runs the per-bit edge counter and the frame bit counter, and steps through the start, data, parity and stop phases. At each step it issues the enable strobes for the data sampler, start/parity/stop checkers and deserializer, then raises a one-cycle `data_valid` for each clean frame.

## Interface
- `DATA_width`, default 8, number of data bits per frame
- `Prescale_width`, default 6, width of `Prescale` and `edge_cnt`

- `clk`  in  1  system clock, oversampling rate (Prescale × baud)
- `reset_n`  in  1  asynchronous active-low reset
- `RX_IN`  in  1  serial line, idle high
- `Prescale`  in  `Prescale_width`  clocks per bit; legal 4..2^`Prescale_width`−1
- `PAR_EN`  in  1  1 = frame carries a parity bit
- `strt_glitch`  in  1  start checker result, valid at bit end
- `par_err`  in  1  parity checker result, valid at bit end
- `stp_err`  in  1  stop checker result, valid at bit end
- `edge_cnt`  out  `Prescale_width`  clock index within the current bit
- `bit_cnt`  out  `$clog2(DATA_width)`  data bit index
- `dat_samp_en`  out  1  data sampler enable
- `strt_chk_en`  out  1  start checker enable
- `par_chk_en`  out  1  parity checker enable
- `stp_chk_en`  out  1  stop checker enable
- `deser_en`  out  1  deserializer shift strobe
- `data_valid`  out  1  frame accepted, one-cycle pulse

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- Reset values: all outputs 0, including `edge_cnt` and `bit_cnt`. Parity-error flag cleared.
- "Bit end" means a cycle in START, DATA, PARITY or STOP with `edge_cnt` == Prescale_r−1.
- IDLE:
  - `RX_IN`==0 moves to START.
  - `Prescale` is latched into Prescale_r and `PAR_EN` into par_en_r on this transition.
  - Both registers hold for the whole frame. Changes to the live inputs mid-frame are ignored.
- `edge_cnt`:
  - 0 in the first cycle of START.
  - Increments every cycle outside IDLE.
  - Wraps to 0 after Prescale_r−1.
  - Held at 0 in IDLE.
- START, at bit end:
  - `strt_glitch`=1 goes to IDLE. No strobes are issued and no `data_valid`.
  - Otherwise goes to DATA with `bit_cnt`=0.
- DATA, at bit end:
  - `deser_en`=1 for that single cycle.
  - If `bit_cnt` == DATA_width−1: go to PARITY when par_en_r=1, else to STOP.
  - Otherwise `bit_cnt`+1.
- PARITY, at bit end: latch `par_err` into the sticky parity flag, then go to STOP.
- STOP, at bit end:
  - Always go to IDLE.
  - Register `data_valid`=1 for the next cycle only when `stp_err`=0 and the sticky parity flag is 0.
  - Clear the sticky parity flag.
- Enables:
  - `dat_samp_en`=1 in every non-IDLE state.
  - `strt_chk_en`=1 throughout START, `par_chk_en`=1 throughout PARITY, `stp_chk_en`=1 throughout STOP.
  - All enables are decoded from the registered state, so they change on the same edge as the state.
- Back-to-back frames: in the IDLE cycle carrying `data_valid`, `RX_IN`=0 starts a new frame immediately.
- Asynchronous reset mid-frame: immediate return to IDLE with all reset values. The partial frame is discarded.

## Timing
- Cycle 0 is the first START cycle, one clock after `RX_IN` is sampled low in IDLE.
- Frame length is F = Prescale_r × (2 + DATA_width + par_en_r) cycles.
- `data_valid` is high in cycle F. Example: Prescale=8 with parity gives cycle 88; without parity, cycle 80.
- `deser_en` for data bit k falls in cycle Prescale_r × (k+2) − 1.
- The checker inputs are only looked at during their bit-end cycle; their values at any other time are don't-care.

## Configuration
- Macro: `UART_RX_FRAME_ERR_EN`.
- Defined:
  - Adds output `frame_err` (1 bit, reset 0).
  - `frame_err` pulses for one cycle in the same cycle a `data_valid` would have appeared, whenever the frame is dropped for `stp_err` or the sticky parity flag.
  - A start glitch does not raise `frame_err`.
- Undefined: the port is absent and erroneous frames are dropped silently.

## Test plan
- Clean frame: Prescale=8, PAR_EN=1, checker errors all 0 → `deser_en` pulses at cycles 15, 23 … 71; `par_chk_en` high in cycles 72–79; `data_valid` high in cycle 88 only.
- Parity error: as above with `par_err`=1 at cycle 79 → no `data_valid`; `frame_err`=1 at cycle 88 when `UART_RX_FRAME_ERR_EN` is defined.
- Start glitch: `strt_glitch`=1 at cycle 7 → IDLE at cycle 8; `edge_cnt`=0; no `deser_en` at any point.
- No parity: Prescale=4, PAR_EN=0 → `par_chk_en` never asserts; `data_valid` in cycle 40.
- Back-to-back: `RX_IN` held low during the `data_valid` cycle → START in the next cycle; `Prescale` changed to 16 mid-frame takes effect only on the second frame.
- Reset: `reset_n` pulsed low at cycle 30 → all outputs 0 and state IDLE asynchronously; a subsequent clean frame completes normally.
